// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller around a 16-bit ALU with an internal
// 16x16 register file, a valid/ready instruction port and a persistent
// {N,Z,F,L,C} flags register.
// Optional feature macro: ALU_SEQ_IMM_EN adds the Imm/ImmSel source-operand path.
// done/err are registered out of WB, so they are high in the first cycle in
// which the committed register, Flags and result values are visible.
module alu_sequencer #(
    parameter int         NREGS         = 16,
    parameter logic [3:0] ILLEGAL_FIRST = 4'b1011
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  OpCode,
    input  logic [3:0]  RdestIdx,
    input  logic [3:0]  RsrcIdx,
`ifdef ALU_SEQ_IMM_EN
    input  logic [7:0]  Imm,
    input  logic        ImmSel,
`endif
    input  logic        host_wr_en,
    input  logic [3:0]  host_wr_addr,
    input  logic [15:0] host_wr_data,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data,
    output logic        done,
    output logic        err,
    output logic [15:0] result,
    output logic [4:0]  Flags
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_CMP  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_LSH  = 4'd7;
    localparam logic [3:0] OP_RSH  = 4'd8;
    localparam logic [3:0] OP_ARSH = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] regs_q [NREGS];
    logic [15:0] regs_d [NREGS];
    logic [3:0]  op_q, op_d;
    logic [3:0]  rd_q, rd_d;
    logic [3:0]  rs_q, rs_d;
`ifdef ALU_SEQ_IMM_EN
    logic [7:0]  imm_q, imm_d;
    logic        immsel_q, immsel_d;
`endif
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [15:0] alu_out_q, alu_out_d;
    logic [4:0]  alu_flags_q, alu_flags_d;
    logic [15:0] result_q, result_d;
    logic [4:0]  flags_q, flags_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    // ALU datapath: returns {N, Z, F, L, C, out}. N/Z/L compare Rdest against
    // Rsrc (signed less, equal, unsigned less); F is signed overflow and C is
    // carry for ADD or no-borrow for SUB/CMP.
    function automatic logic [20:0] alu_calc(input logic [3:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        logic [16:0] sum;
        logic [15:0] y;
        logic n, z, f, l, c;
        sa  = a;
        sb  = b;
        sum = 17'd0;
        y   = 16'd0;
        n   = (sa < sb);
        z   = (a == b);
        l   = (a < b);
        f   = 1'b0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[15:0];
                c   = sum[16];
                f   = (a[15] == b[15]) && (y[15] != a[15]);
            end
            OP_SUB, OP_CMP: begin
                sum = {1'b0, a} + {1'b0, ~b} + 17'd1;
                y   = sum[15:0];
                c   = sum[16];
                f   = (a[15] != b[15]) && (y[15] != a[15]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_LSH:  y = {a[14:0], 1'b0};
            OP_RSH:  y = {1'b0, a[15:1]};
            OP_ARSH: y = {a[15], a[15:1]};
            OP_MUL:  y = a * b;
            default: y = 16'd0;
        endcase
        return {n, z, f, l, c, y};
    endfunction

    // Next-state, datapath and write-back decisions for the four-state sequence.
    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
`ifdef ALU_SEQ_IMM_EN
        imm_d       = imm_q;
        immsel_d    = immsel_q;
`endif
        opa_d       = opa_q;
        opb_d       = opb_q;
        alu_out_d   = alu_out_q;
        alu_flags_d = alu_flags_q;
        result_d    = result_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Host write lands first so an instruction accepted on the
                // same edge fetches the freshly written value.
                if (host_wr_en) begin
                    regs_d[host_wr_addr] = host_wr_data;
                end
                if (instr_valid) begin
                    op_d     = OpCode;
                    rd_d     = RdestIdx;
                    rs_d     = RsrcIdx;
`ifdef ALU_SEQ_IMM_EN
                    imm_d    = Imm;
                    immsel_d = ImmSel;
`endif
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                opa_d = regs_q[rd_q];
                opb_d = regs_q[rs_q];
`ifdef ALU_SEQ_IMM_EN
                if (immsel_q) begin
                    opb_d = {{8{imm_q[7]}}, imm_q};
                end
`endif
                state_d = S_EXEC;
            end
            S_EXEC: begin
                {alu_flags_d, alu_out_d} = alu_calc(op_q, opa_q, opb_q);
                state_d = S_WB;
            end
            S_WB: begin
                done_d = 1'b1;
                if (op_q >= ILLEGAL_FIRST) begin
                    err_d = 1'b1;
                end else begin
                    result_d = alu_out_q;
                    if (op_q != OP_CMP) begin
                        regs_d[rd_q] = alu_out_q;
                    end
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        flags_d = alu_flags_q;
                    end else if (op_q == OP_CMP) begin
                        // CMP refreshes N, Z, L and keeps the old F and C.
                        flags_d = {alu_flags_q[4], alu_flags_q[3], flags_q[2],
                                   alu_flags_q[1], flags_q[0]};
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Architectural state: FSM, register file, flags, result and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= 16'd0;
            end
            result_q <= 16'd0;
            flags_q  <= 5'd0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            regs_q   <= regs_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Pipeline holding registers; always written before being consumed.
    always_ff @(posedge clk) begin
        op_q        <= op_d;
        rd_q        <= rd_d;
        rs_q        <= rs_d;
`ifdef ALU_SEQ_IMM_EN
        imm_q       <= imm_d;
        immsel_q    <= immsel_d;
`endif
        opa_q       <= opa_d;
        opb_q       <= opb_d;
        alu_out_q   <= alu_out_d;
        alu_flags_q <= alu_flags_d;
    end

    assign instr_ready = (state_q == S_IDLE);
    assign dbg_data    = regs_q[dbg_addr];
    assign done        = done_q;
    assign err         = err_q;
    assign result      = result_q;
    assign Flags       = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: edge-level behavioural model plus a
// per-cycle compare process, directed cases with literal expectations, and a
// randomized run.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  OpCode = 4'd0;
    logic [3:0]  RdestIdx = 4'd0;
    logic [3:0]  RsrcIdx = 4'd0;
`ifdef ALU_SEQ_IMM_EN
    logic [7:0]  Imm = 8'd0;
    logic        ImmSel = 1'b0;
`endif
    logic        host_wr_en = 1'b0;
    logic [3:0]  host_wr_addr = 4'd0;
    logic [15:0] host_wr_data = 16'd0;
    logic [3:0]  dbg_addr = 4'd0;
    logic [15:0] dbg_data;
    logic        done;
    logic        err;
    logic [15:0] result;
    logic [4:0]  Flags;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    alu_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .OpCode(OpCode), .RdestIdx(RdestIdx), .RsrcIdx(RsrcIdx),
`ifdef ALU_SEQ_IMM_EN
        .Imm(Imm), .ImmSel(ImmSel),
`endif
        .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .done(done), .err(err), .result(result), .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_regs [16];
    logic [4:0]  m_flags = 5'd0;
    logic [15:0] m_result = 16'd0;
    bit          pend = 0;
    int          age = 0;
    bit          exp_done = 0;
    bit          exp_err = 0;
    int          p_op = 0;
    int          p_rd = 0;
    logic [15:0] p_out;
    logic [4:0]  p_fl;

    initial for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;

    function automatic longint to_s(input longint v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void ref_exec(input int op, input longint a, input longint b,
                                     output logic [15:0] o, output logic [4:0] fl);
        longint sa, sb, r, sr;
        bit n, z, f, l, c;
        sa = to_s(a); sb = to_s(b);
        n = sa < sb; z = (a == b); l = a < b; f = 0; c = 0; r = 0;
        case (op)
            0: begin r = a + b; c = (r > 65535); sr = sa + sb; f = (sr > 32767) || (sr < -32768); end
            1, 2: begin r = a - b + 65536; c = (a >= b); sr = sa - sb; f = (sr > 32767) || (sr < -32768); end
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = 65535 - a;
            7: r = a * 2;
            8: r = a / 2;
            9: r = a / 2 + ((a >= 32768) ? 32768 : 0);
            10: r = a * b;
            default: r = 0;
        endcase
        o  = 16'(r % 65536);
        fl = {n, z, f, l, c};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        longint a, b;
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'd0;
            m_flags = 5'd0; m_result = 16'd0;
            pend = 0; age = 0; exp_done = 0; exp_err = 0;
        end else begin
            exp_done = 0; exp_err = 0;
            if (pend) begin
                age++;
                if (age == 3) begin
                    pend = 0;
                    exp_done = 1;
                    if (p_op >= 11) begin
                        exp_err = 1;
                    end else begin
                        m_result = p_out;
                        if (p_op != 2) m_regs[p_rd] = p_out;
                        if (p_op <= 1) m_flags = p_fl;
                        if (p_op == 2) m_flags = {p_fl[4], p_fl[3], m_flags[2], p_fl[1], m_flags[0]};
                    end
                end
            end else begin
                if (host_wr_en) m_regs[host_wr_addr] = host_wr_data;
                if (instr_valid) begin
                    p_op = int'(OpCode);
                    p_rd = int'(RdestIdx);
                    a = longint'(m_regs[RdestIdx]);
                    b = longint'(m_regs[RsrcIdx]);
`ifdef ALU_SEQ_IMM_EN
                    if (ImmSel) b = (Imm >= 8'd128) ? longint'(Imm) + 65280 : longint'(Imm);
`endif
                    ref_exec(p_op, a, b, p_out, p_fl);
                    pend = 1;
                    age = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            chk("ready", {15'd0, instr_ready}, {15'd0, !pend});
            chk("done", {15'd0, done}, {15'd0, exp_done});
            chk("err", {15'd0, err}, {15'd0, exp_err});
            chk("flags", {11'd0, Flags}, {11'd0, m_flags});
            chk("result", result, m_result);
            chk("dbg_data", dbg_data, m_regs[dbg_addr]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic setup();
        @(negedge clk);
        #2;
    endtask

    task automatic host_wr(input int addr, input int data);
        setup();
        instr_valid = 0;
        host_wr_en = 1; host_wr_addr = 4'(addr); host_wr_data = 16'(data);
        setup();
        host_wr_en = 0;
    endtask

    task automatic peek(input string name, input int addr, input int exp);
        dbg_addr = 4'(addr);
        #1;
        chk(name, dbg_data, 16'(exp));
    endtask

    task automatic issue(input int op, input int rd, input int rs, input bit hold,
                         input bit hw, input int haddr, input int hdata,
                         output int lat, output bit err_seen);
        bit seen;
        setup();
        instr_valid = 1; OpCode = 4'(op); RdestIdx = 4'(rd); RsrcIdx = 4'(rs);
        host_wr_en = hw; host_wr_addr = 4'(haddr); host_wr_data = 16'(hdata);
        @(posedge clk);
        lat = 0; seen = 0; err_seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin seen = 1; err_seen = err; end
            #2;
            host_wr_en = 0;
            if (i == 0 && !hold) instr_valid = 0;
            if (i == 1) instr_valid = 0;
        end
        instr_valid = 0;
        if (!seen) chk("done_timeout", 16'd0, 16'd1);
    endtask

    initial begin
        int lat;
        bit e;
        int d;
        repeat (3) setup();
        reset_n = 1;
        setup();
        chk("rst_ready", {15'd0, instr_ready}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_err", {15'd0, err}, 16'd0);
        chk("rst_flags", {11'd0, Flags}, 16'd0);
        chk("rst_result", result, 16'd0);
        peek("rst_r15", 15, 0);
        chk_en = 1;

        // Reset while an ADD to R1 is in EXEC.
        host_wr(1, 7);
        peek("pre_r1", 1, 7);
        setup();
        instr_valid = 1; OpCode = 4'd0; RdestIdx = 4'd1; RsrcIdx = 4'd1;
        setup();
        instr_valid = 0;
        setup();
        reset_n = 0;
        setup();
        setup();
        reset_n = 1;
        for (int i = 0; i < 5; i++) begin
            setup();
            chk("midrst_no_done", {15'd0, done}, 16'd0);
        end
        peek("midrst_r1", 1, 0);
        chk("midrst_flags", {11'd0, Flags}, 16'd0);
        chk("midrst_ready", {15'd0, instr_ready}, 16'd1);

        // SUB R1,R2 with 5 and 3.
        host_wr(1, 5);
        host_wr(2, 3);
        issue(1, 1, 2, 0, 0, 0, 0, lat, e);
        chk("sub_latency", 16'(lat), 16'd4);
        peek("sub_r1", 1, 2);
        chk("sub_flags", {11'd0, Flags}, 16'b00001);
        chk("sub_result", result, 16'd2);

        // ADD wrap-around.
        host_wr(1, 16'hFFFF);
        host_wr(2, 1);
        issue(0, 1, 2, 0, 0, 0, 0, lat, e);
        peek("add_r1", 1, 0);
        chk("add_flags", {11'd0, Flags}, 16'b10001);

        // CMP keeps C and F.
        host_wr(3, 3);
        host_wr(4, 5);
        issue(2, 3, 4, 0, 0, 0, 0, lat, e);
        peek("cmp_r3", 3, 3);
        chk("cmp_flags", {11'd0, Flags}, 16'b10011);
        chk("cmp_result", result, 16'hFFFE);

        // Illegal opcode with valid held through FETCH.
        issue(12, 3, 4, 1, 0, 0, 0, lat, e);
        chk("ill_err", {15'd0, e}, 16'd1);
        chk("ill_latency", 16'(lat), 16'd4);
        chk("ill_flags", {11'd0, Flags}, 16'b10011);
        chk("ill_result", result, 16'hFFFE);
        peek("ill_r3", 3, 3);
        for (int i = 0; i < 3; i++) begin
            setup();
            chk("ill_no_redo", {15'd0, done}, 16'd0);
        end

        // Host write on the accept edge is seen by FETCH.
        issue(0, 6, 6, 0, 1, 6, 16'h1234, lat, e);
        peek("samedge_r6", 6, 16'h2468);

        // Host write while busy is dropped.
        host_wr(7, 16'h00AA);
        setup();
        instr_valid = 1; OpCode = 4'd6; RdestIdx = 4'd8; RsrcIdx = 4'd0;
        setup();
        instr_valid = 0; host_wr_en = 1; host_wr_addr = 4'd7; host_wr_data = 16'h5555;
        setup();
        host_wr_en = 0;
        repeat (4) setup();
        peek("busy_hw_r7", 7, 16'h00AA);

`ifdef ALU_SEQ_IMM_EN
        host_wr(5, 10);
        Imm = 8'hFE; ImmSel = 1;
        issue(0, 5, 0, 0, 0, 0, 0, lat, e);
        ImmSel = 0;
        peek("imm_r5", 5, 8);
        chk("imm_c", {15'd0, Flags[0]}, 16'd1);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int cyc = 0; cyc < 2000; cyc++) begin
            setup();
            if (cyc == 1000) reset_n = 0;
            if (cyc == 1002) reset_n = 1;
            instr_valid = ($urandom % 3) == 0;
            OpCode = 4'($urandom);
            RdestIdx = 4'($urandom);
            RsrcIdx = 4'($urandom);
`ifdef ALU_SEQ_IMM_EN
            Imm = 8'($urandom);
            ImmSel = ($urandom % 3) == 0;
`endif
            host_wr_en = ($urandom % 4) == 0;
            host_wr_addr = 4'($urandom);
            case ($urandom % 6)
                0: d = 0;
                1: d = 16'hFFFF;
                2: d = 16'h8000;
                3: d = 16'h7FFF;
                4: d = 1;
                default: d = int'($urandom % 65536);
            endcase
            host_wr_data = 16'(d);
            dbg_addr = 4'($urandom);
        end
        setup();
        instr_valid = 0; host_wr_en = 0;
        repeat (6) setup();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
